// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial wide-add sequencer: streams operand bytes LSB-first through an external
// 8-bit adder slice, chains the carry in a register, and hands the assembled sum downstream.
module byte_serial_add_ctrl #(
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [8*NUM_BYTES-1:0] A_i,
    input  logic [8*NUM_BYTES-1:0] B_i,
    input  logic                   cin_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [8*NUM_BYTES-1:0] SUM_o,
    output logic                   cout_o,
    output logic [7:0]             add_A_o,
    output logic [7:0]             add_B_o,
    output logic                   add_cin_o,
    input  logic [7:0]             add_SUM_i,
    input  logic                   add_cout_i
);

    localparam int W  = 8 * NUM_BYTES;
    localparam int CW = $clog2(NUM_BYTES);
    localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    sum_reg;
    logic            carry_reg;
    logic            cout_reg;
    logic            ready_reg;
    logic            valid_reg;

    logic [7:0] a_bytes [NUM_BYTES];
    logic [7:0] b_bytes [NUM_BYTES];

    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
            assign a_bytes[gi] = a_reg[8*gi +: 8];
            assign b_bytes[gi] = b_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid_i) begin
                        a_reg     <= A_i;
                        b_reg     <= B_i;
                        carry_reg <= cin_i;
                        cnt_reg   <= '0;
                        ready_reg <= 1'b0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[8*cnt_reg +: 8] <= add_SUM_i;
                    carry_reg               <= add_cout_i;
                    if (cnt_reg == LAST) begin
                        cout_reg  <= add_cout_i;
                        valid_reg <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    // Result registers stay frozen here until the consumer takes them.
                    if (ready_i) begin
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // The slice is only driven while a byte is in flight; otherwise it sees zeros.
    always_comb begin
        add_A_o   = 8'h00;
        add_B_o   = 8'h00;
        add_cin_o = 1'b0;
        if (state_reg == RUN) begin
            add_A_o   = a_bytes[cnt_reg];
            add_B_o   = b_bytes[cnt_reg];
            add_cin_o = carry_reg;
        end
    end

    assign ready_o = ready_reg;
    assign valid_o = valid_reg;
    assign SUM_o   = sum_reg;
    assign cout_o  = cout_reg;

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Self-checking bench for byte_serial_add_ctrl with a behavioural 8-bit adder slice attached.
module tb_byte_serial_add_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic          ready_out;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          cin;
    logic          valid_out;
    logic          ready_in;
    logic [W-1:0]  sum;
    logic          cout;
    logic [7:0]    add_a;
    logic [7:0]    add_b;
    logic          add_cin;
    logic [7:0]    add_sum;
    logic          add_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Combinational 8-bit adder slice.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

    byte_serial_add_ctrl #(.NUM_BYTES(NB)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (valid_in),
        .ready_o    (ready_out),
        .A_i        (a_in),
        .B_i        (b_in),
        .cin_i      (cin),
        .valid_o    (valid_out),
        .ready_i    (ready_in),
        .SUM_o      (sum),
        .cout_o     (cout),
        .add_A_o    (add_a),
        .add_B_o    (add_b),
        .add_cin_o  (add_cin),
        .add_SUM_i  (add_sum),
        .add_cout_i (add_cout)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        int           bp;
        bit           noise;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Carry entering byte k, taken from the plain sum of the low 8*k bits.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c, input int k);
        logic [63:0] mask;
        logic [63:0] s;
        mask = (k == 0) ? 64'd0 : ((64'd1 << (8 * k)) - 64'd1);
        s = ({32'd0, a} & mask) + ({32'd0, b} & mask) + {63'd0, c};
        return s[8*k];
    endfunction

    // Caller is positioned just after an edge with the DUT idle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] exp_sum, input logic exp_cout,
                          input int bp, input bit noise, input string tag);
        logic [W-1:0] ab;
        logic [W-1:0] bb;
        a_in = a; b_in = b; cin = c; valid_in = 1'b1; ready_in = 1'b0;
        step();
        valid_in = 1'b0;
        check({tag, " ready_o after accept"}, {63'd0, ready_out}, 64'd0);
        for (int k = 0; k < NB; k++) begin
            ab = a >> (8 * k);
            bb = b >> (8 * k);
            check({tag, " valid_o during run"}, {63'd0, valid_out}, 64'd0);
            check({tag, " add_A_o"}, {56'd0, add_a}, {56'd0, ab[7:0]});
            check({tag, " add_B_o"}, {56'd0, add_b}, {56'd0, bb[7:0]});
            check({tag, " add_cin_o"}, {63'd0, add_cin}, {63'd0, carry_into(a, b, c, k)});
            step();
        end
        check({tag, " valid_o at latency"}, {63'd0, valid_out}, 64'd1);
        check({tag, " SUM_o"}, {32'd0, sum}, {32'd0, exp_sum});
        check({tag, " cout_o"}, {63'd0, cout}, {63'd0, exp_cout});
        $display("op %s: A=%h B=%h cin=%b -> SUM=%h cout=%b", tag, a, b, c, sum, cout);
        for (int i = 0; i < bp; i++) begin
            if (noise) begin
                valid_in = 1'b1; a_in = 32'h0BADF00D; b_in = 32'h10000000; cin = 1'b0;
            end
            step();
            check({tag, " valid_o held"}, {63'd0, valid_out}, 64'd1);
            check({tag, " ready_o held"}, {63'd0, ready_out}, 64'd0);
            check({tag, " SUM_o held"}, {32'd0, sum}, {32'd0, exp_sum});
            check({tag, " cout_o held"}, {63'd0, cout}, {63'd0, exp_cout});
        end
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        check({tag, " valid_o after take"}, {63'd0, valid_out}, 64'd0);
        check({tag, " ready_o after take"}, {63'd0, ready_out}, 64'd1);
        check({tag, " SUM_o kept in idle"}, {32'd0, sum}, {32'd0, exp_sum});
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   full;
        bit           saw_valid;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 0, 1'b0};
        vecs[1] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 0, 1'b0};
        vecs[2] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 5, 1'b1};
        vecs[4] = '{32'h0BADF00D, 32'h10000000, 1'b0, 32'h1BADF00D, 1'b0, 2, 1'b0};
        vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 0, 1'b0};

        // Reset held for three edges while upstream offers operands.
        rst_n = 1'b0; valid_in = 1'b1; ready_in = 1'b0;
        a_in = 32'hDEADBEEF; b_in = 32'h01234567; cin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset ready_o", {63'd0, ready_out}, 64'd1);
            check("reset valid_o", {63'd0, valid_out}, 64'd0);
            check("reset SUM_o", {32'd0, sum}, 64'd0);
            check("reset cout_o", {63'd0, cout}, 64'd0);
            check("reset add bus", {47'd0, add_a, add_b, add_cin}, 64'd0);
        end
        valid_in = 1'b0;
        rst_n = 1'b1;
        step();
        check("idle after reset ready_o", {63'd0, ready_out}, 64'd1);
        check("idle after reset add bus", {47'd0, add_a, add_b, add_cin}, 64'd0);

        for (int v = 0; v < 6; v++)
            run_op(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].exp_sum, vecs[v].exp_cout,
                   vecs[v].bp, vecs[v].noise, $sformatf("vec%0d", v));

        // Back-to-back: valid_i held high, ready_i held high.
        a_in = 32'h00000001; b_in = 32'h00000002; cin = 1'b0;
        valid_in = 1'b1; ready_in = 1'b1;
        step();
        check("b2b first accept", {63'd0, ready_out}, 64'd0);
        for (int i = 0; i < NB; i++) step();
        check("b2b first valid_o", {63'd0, valid_out}, 64'd1);
        check("b2b first SUM_o", {32'd0, sum}, 64'h3);
        check("b2b first cout_o", {63'd0, cout}, 64'd0);
        $display("op b2b0: A=00000001 B=00000002 cin=0 -> SUM=%h cout=%b", sum, cout);
        a_in = 32'h80000000; b_in = 32'h80000000;
        step();
        check("b2b idle ready_o", {63'd0, ready_out}, 64'd1);
        check("b2b idle valid_o", {63'd0, valid_out}, 64'd0);
        step();
        valid_in = 1'b0;
        check("b2b second accept at +6", {63'd0, ready_out}, 64'd0);
        for (int i = 0; i < NB; i++) step();
        check("b2b second valid_o", {63'd0, valid_out}, 64'd1);
        check("b2b second SUM_o", {32'd0, sum}, 64'h0);
        check("b2b second cout_o", {63'd0, cout}, 64'd1);
        $display("op b2b1: A=80000000 B=80000000 cin=0 -> SUM=%h cout=%b", sum, cout);
        step();
        ready_in = 1'b0;
        check("b2b back to idle", {63'd0, ready_out}, 64'd1);

        // Reset after the second RUN byte discards the operation.
        a_in = 32'hA5A5A5A5; b_in = 32'h5A5A5A5A; cin = 1'b1; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst ready_o", {63'd0, ready_out}, 64'd1);
        check("midrst valid_o", {63'd0, valid_out}, 64'd0);
        check("midrst SUM_o", {32'd0, sum}, 64'd0);
        check("midrst cout_o", {63'd0, cout}, 64'd0);
        check("midrst add bus", {47'd0, add_a, add_b, add_cin}, 64'd0);
        saw_valid = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < NB + 3; i++) begin
            step();
            if (valid_out) saw_valid = 1'b1;
        end
        ready_in = 1'b0;
        check("midrst no stray valid_o", {63'd0, saw_valid}, 64'd0);
        $display("op midrst: aborted A=A5A5A5A5 B=5A5A5A5A, ready_o=%b", ready_out);

        // Random operands against the arithmetic model.
        for (int r = 0; r < 20; r++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            if (r % 5 == 0) rb = ~ra;
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_op(ra, rb, rc, full[W-1:0], full[W], int'($urandom_range(0, 3)), 1'b0,
                   $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_serial_add_ctrl.md
Name: byte_serial_add_ctrl

Overview:
- Multi-cycle sequencer for wide additions on the shared 8-bit ripple adder slice.
- Latches two (8*NUM_BYTES)-bit operands plus carry-in through a valid/ready handshake.
- Feeds the external 8-bit adder one byte per cycle, LSB first, and chains the carry through a register.
- Consumes each byte's sum and carry-out, assembles the wide result, and presents it downstream through a second valid/ready handshake.

Parameters:
- NUM_BYTES, 4, number of 8-bit slices per operation; operand width is 8*NUM_BYTES; legal range 2..16.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset; synchronous, active-low.
- valid_i  input  1  upstream operands valid.
- ready_o  output  1  block can accept operands.
- A_i  input  8*NUM_BYTES  operand A.
- B_i  input  8*NUM_BYTES  operand B.
- cin_i  input  1  initial carry-in.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- SUM_o  output  8*NUM_BYTES  assembled sum.
- cout_o  output  1  final carry-out.
- add_A_o  output  8  byte of A to the adder slice.
- add_B_o  output  8  byte of B to the adder slice.
- add_cin_o  output  1  carry to the adder slice.
- add_SUM_i  input  8  sum from the adder slice; combinational from add_* outputs.
- add_cout_i  input  1  carry-out from the adder slice.

Behaviour:
Reset (rst_ni low at a clock edge):
- State goes to IDLE. Byte counter, operand registers, carry register, SUM_o and cout_o all go to 0.
- valid_o is 0; ready_o is 1 after the edge.
- Applies in any state; an in-flight operation is discarded and produces no output.

FSM states are IDLE, RUN and DONE.

IDLE:
- ready_o=1, valid_o=0.
- add_A_o, add_B_o and add_cin_o are driven to 0.
- On valid_i and ready_o at an edge: latch A_i and B_i; carry_q<=cin_i; cnt<=0; go to RUN.
- valid_i low: stay in IDLE.

RUN:
- ready_o=0, valid_o=0.
- Adder drive: add_A_o=A_q[8*cnt+:8], add_B_o=B_q[8*cnt+:8], add_cin_o=carry_q.
- Each edge: SUM_q[8*cnt+:8]<=add_SUM_i; carry_q<=add_cout_i.
- If cnt==NUM_BYTES-1: cout_q<=add_cout_i; go to DONE. Otherwise cnt<=cnt+1.
- valid_i and the operand inputs are ignored.

DONE:
- valid_o=1, ready_o=0; add_* outputs are driven to 0.
- SUM_o and cout_o are held stable until the handshake completes.
- ready_i high at an edge: go to IDLE (valid_o falls the next cycle).
- ready_i low: stay in DONE indefinitely; any valid_i is ignored.

Timing:
- Latency: accept edge T0 gives valid_o high from edge T0+NUM_BYTES.
- Throughput is at most one operation per NUM_BYTES+2 cycles (accept, NUM_BYTES RUN cycles, DONE).
- ready_o depends only on state, never combinationally on valid_i. valid_o depends only on state, never on ready_i.

Arithmetic:
- {cout_o,SUM_o} = A + B + cin, computed modulo 2^(8*NUM_BYTES+1).
- Bytes are processed little-endian; there is no overflow flag.

Counter:
- cnt width is clog2(NUM_BYTES); it never exceeds NUM_BYTES-1.
- cnt is reset to 0 on every accept.

Outputs between operations:
- SUM_o and cout_o are registers, so they keep the last result in IDLE.
- Only valid_o qualifies the result.

Test Plan (NUM_BYTES=4, with adder_8bit connected to the add_* ports):
- Accept A=0xFFFFFFFF, B=0x00000001, cin=0 with ready_i=1 -> valid_o rises exactly 4 cycles after accept; SUM_o=0x00000000, cout_o=1; add_cin_o is 0,1,1,1 across the RUN cycles.
- A=0x12345678, B=0x11111111, cin=1 -> add_A_o sequence 0x78,0x56,0x34,0x12; add_B_o 0x11 each cycle; SUM_o=0x2345678A, cout_o=0.
- Backpressure: result ready, ready_i=0 for 5 cycles, valid_i=1 with new operands -> valid_o stays 1, SUM_o/cout_o unchanged, ready_o stays 0, new operands ignored. ready_i=1 -> IDLE next cycle, then the new operands are accepted.
- Reset mid-operation: rst_ni=0 at the edge after the 2nd RUN byte -> next cycle state is IDLE, ready_o=1, valid_o=0, SUM_o=0, cout_o=0; no valid_o pulse from the aborted operation.
- Back-to-back: valid_i held high with ready_i=1 for ops 0x00000001+0x00000002 then 0x80000000+0x80000000 -> results 0x00000003/cout 0, then 0x00000000/cout 1; the second accept occurs 6 cycles after the first.
- Reset defaults: hold rst_ni=0 for 3 cycles -> all outputs 0 except ready_o=1 (after the first reset edge); valid_i during reset is not accepted.
